// File: rtl/fadd_arb.sv
`timescale 1ns/1ps
// Two-requester arbiter sharing one single-precision adder; optional subtract via FADD_ARB_SUB_EN.
// Latency: transfer at edge k -> response valid for the cycle between edges k+1 and k+2.
// Backpressure: ready is combinational (hold, valids, priority pointer); responses cannot be stalled.

// Combinational IEEE-754 single-precision adder, round-to-nearest-even, with denormals.
// Latency: zero (pure combinational).
// Backpressure: none; the result follows the operands directly.
module fadd_arb_fadd (
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic [31:0] d,
    output logic        overflow
);

    logic        swap;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [8:0]  ea_eff;
    logic [8:0]  eb_eff;
    logic [8:0]  dexp;
    logic [26:0] bx;
    logic [26:0] bsh;
    logic        sticky;
    logic        eff_sub;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [8:0]  shamt;
    logic [26:0] norm;
    logic [8:0]  e_res;
    logic [8:0]  exp_field;
    logic        rnd;
    logic [31:0] mag;
    logic        res_sign;
    logic        s_nan;
    logic        t_nan;
    logic        s_inf;
    logic        t_inf;

    // Leading-zero count over the 27-bit working mantissa (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [26:0] x);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (x[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // Align, add/subtract, normalise, round and resolve special operands.
    always_comb begin
        s_nan = (&s[30:23]) & (|s[22:0]);
        t_nan = (&t[30:23]) & (|t[22:0]);
        s_inf = (&s[30:23]) & ~(|s[22:0]);
        t_inf = (&t[30:23]) & ~(|t[22:0]);

        // Larger magnitude goes to 'a' so the subtraction never goes negative.
        swap   = (t[30:0] > s[30:0]);
        a      = swap ? t : s;
        b      = swap ? s : t;
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = {|ea, a[22:0]};
        mb     = {|eb, b[22:0]};
        ea_eff = (ea == 8'd0) ? 9'd1 : {1'b0, ea};
        eb_eff = (eb == 8'd0) ? 9'd1 : {1'b0, eb};
        dexp   = ea_eff - eb_eff;

        // Three extra low bits: guard, round, sticky.
        bx = {mb, 3'b000};
        if (dexp >= 9'd27) begin
            bsh    = '0;
            sticky = |bx;
        end else begin
            bsh    = bx >> dexp;
            sticky = |(bx & ~({27{1'b1}} << dexp));
        end
        bsh[0] = bsh[0] | sticky;

        eff_sub = a[31] ^ b[31];
        sum     = eff_sub ? ({1'b0, ma, 3'b000} - {1'b0, bsh})
                          : ({1'b0, ma, 3'b000} + {1'b0, bsh});
        lz      = lzc27(sum[26:0]);

        shamt = '0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            e_res = ea_eff + 9'd1;
        end else begin
            // Left shift stops at the minimum exponent; the result is then denormal.
            shamt = ({4'b0, lz} < (ea_eff - 9'd1)) ? {4'b0, lz} : (ea_eff - 9'd1);
            norm  = sum[26:0] << shamt;
            e_res = ea_eff - shamt;
        end

        exp_field = norm[26] ? e_res : 9'd0;
        rnd       = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Rounding carry ripples into the exponent field, covering both mantissa overflow
        // and denormal-to-normal promotion.
        mag       = {exp_field, norm[25:3]} + {31'd0, rnd};

        // Exact cancellation yields +0; two zeros of the same sign keep it.
        res_sign = (sum == 28'd0) ? (a[31] & b[31]) : a[31];

        overflow = 1'b0;
        if (s_nan | t_nan | (s_inf & t_inf & (s[31] ^ t[31]))) begin
            d = 32'h7FC0_0000;
        end else if (s_inf | t_inf) begin
            d = s_inf ? s : t;
        end else if (mag[31:23] >= 9'd255) begin
            d        = {res_sign, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else begin
            d = {res_sign, mag[30:0]};
        end
    end

endmodule

// Two-requester round-robin front end to a single shared adder (FADD_ARB_SUB_EN adds subtract).
// Latency: two edges from transfer to the registered response pulse.
// Backpressure: hold blocks new grants only; responses are never stalled.
module fadd_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_s,
    input  logic [31:0] req0_t,
`ifdef FADD_ARB_SUB_EN
    input  logic        req0_sub,
`endif
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_s,
    input  logic [31:0] req1_t,
`ifdef FADD_ARB_SUB_EN
    input  logic        req1_sub,
`endif
    output logic        resp0_valid,
    output logic [31:0] resp0_d,
    output logic        resp0_ovf,
    output logic        resp1_valid,
    output logic [31:0] resp1_d,
    output logic        resp1_ovf,
    output logic        busy
);

    logic        ptr;
    logic        xfer0;
    logic        xfer1;
    logic        s1_valid;
    logic        s1_id;
    logic [31:0] s1_s;
    logic [31:0] s1_t;
    logic [31:0] fa_t;
    logic [31:0] fa_d;
    logic        fa_ovf;
`ifdef FADD_ARB_SUB_EN
    logic        s1_sub;
`endif

    // Grant: a lone requester wins; on contention the pointer decides; hold or reset blocks all.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && !hold) begin
            if (req0_valid && (!req1_valid || !ptr)) req0_ready = 1'b1;
            else if (req1_valid)                     req1_ready = 1'b1;
        end
    end

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    // Stage 1: capture the accepted operation and move the pointer to the requester not served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_s     <= '0;
            s1_t     <= '0;
            ptr      <= 1'b0;
`ifdef FADD_ARB_SUB_EN
            s1_sub   <= 1'b0;
`endif
        end else begin
            s1_valid <= xfer0 | xfer1;
            if (xfer0 | xfer1) begin
                s1_id  <= xfer1;
                s1_s   <= xfer1 ? req1_s : req0_s;
                s1_t   <= xfer1 ? req1_t : req0_t;
                ptr    <= xfer0;
`ifdef FADD_ARB_SUB_EN
                s1_sub <= xfer1 ? req1_sub : req0_sub;
`endif
            end
        end
    end

`ifdef FADD_ARB_SUB_EN
    assign fa_t = {s1_t[31] ^ s1_sub, s1_t[30:0]};
`else
    assign fa_t = s1_t;
`endif

    fadd_arb_fadd u_fadd (
        .s        (s1_s),
        .t        (fa_t),
        .d        (fa_d),
        .overflow (fa_ovf)
    );

    // Stage 2: route the adder result to the issuing requester; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp0_valid <= 1'b0;
            resp0_d     <= '0;
            resp0_ovf   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_d     <= '0;
            resp1_ovf   <= 1'b0;
        end else begin
            resp0_valid <= s1_valid & ~s1_id;
            resp1_valid <= s1_valid &  s1_id;
            if (s1_valid && !s1_id) begin
                resp0_d   <= fa_d;
                resp0_ovf <= fa_ovf;
            end
            if (s1_valid && s1_id) begin
                resp1_d   <= fa_d;
                resp1_ovf <= fa_ovf;
            end
        end
    end

    assign busy = s1_valid | resp0_valid | resp1_valid;

endmodule

// File: tb/tb_fadd_arb.sv
`timescale 1ns/1ps
module tb_fadd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_s, req0_t, req1_s, req1_t;
    logic        req0_sub, req1_sub;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_d, resp1_d;
    logic        resp0_ovf, resp1_ovf;
    logic        busy;

    always #5 clk = ~clk;

    fadd_arb dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_s      (req0_s),
        .req0_t      (req0_t),
`ifdef FADD_ARB_SUB_EN
        .req0_sub    (req0_sub),
`endif
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_s      (req1_s),
        .req1_t      (req1_t),
`ifdef FADD_ARB_SUB_EN
        .req1_sub    (req1_sub),
`endif
        .resp0_valid (resp0_valid),
        .resp0_d     (resp0_d),
        .resp0_ovf   (resp0_ovf),
        .resp1_valid (resp1_valid),
        .resp1_d     (resp1_d),
        .resp1_ovf   (resp1_ovf),
        .busy        (busy)
    );

    typedef struct {
        int          due;
        bit          id;
        logic [31:0] d;
        bit          ovf;
    } exp_t;

    typedef struct {
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] d;
        bit          ovf;
    } vec_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          edges = 0;
    bit          ptr_m = 1'b0;
    logic [31:0] last_d[2];
    bit          last_ovf[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Normal single -> real, exact.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        e = {3'b0, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    // Exact real sum rounded to single, nearest-even; returns {ovf, bits}.
    function automatic logic [32:0] ref_add(input logic [31:0] s, input logic [31:0] t);
        real         r;
        logic [63:0] db;
        int          se;
        logic [52:0] m;
        logic [28:0] rem;
        logic [24:0] m25;
        bit          up;
        r  = to_real(s) + to_real(t);
        db = $realtobits(r);
        if (db[62:0] == 63'd0) return 33'd0;
        se  = int'(db[62:52]) - 1023 + 127;
        m   = {1'b1, db[51:0]};
        rem = m[28:0];
        up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[29]);
        m25 = {1'b0, m[52:29]} + {24'd0, up};
        if (m25[24]) begin
            m25 = m25 >> 1;
            se++;
        end
        if (se >= 255) return {1'b1, db[63], 8'hFF, 23'd0};
        return {1'b0, db[63], 8'(se), m25[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom), 8'($urandom_range(135, 115)), 23'($urandom)};
    endfunction

    function automatic logic [1:0] exp_ready();
        if (rst || hold) return 2'b00;
        case ({req1_valid, req0_valid})
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return ptr_m ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // One clock: check outputs at negedge, then record any transfer at the posedge.
    task automatic step(input bit ovr, input logic [32:0] ovr_res, output logic [1:0] g);
        bit          ev0, ev1, busy_e, id;
        logic [31:0] tt;
        logic [32:0] res;
        @(negedge clk);
        g = exp_ready();
        chk("ready", {req1_ready, req0_ready}, g);
        ev0 = 0;
        ev1 = 0;
        busy_e = (q.size() != 0);
        if (q.size() != 0 && q[0].due == edges) begin
            if (q[0].id) ev1 = 1; else ev0 = 1;
            last_d[q[0].id]   = q[0].d;
            last_ovf[q[0].id] = q[0].ovf;
            void'(q.pop_front());
        end
        chk("resp0_valid", resp0_valid, ev0);
        chk("resp1_valid", resp1_valid, ev1);
        chk("resp0_d", resp0_d, last_d[0]);
        chk("resp0_ovf", resp0_ovf, last_ovf[0]);
        chk("resp1_d", resp1_d, last_d[1]);
        chk("resp1_ovf", resp1_ovf, last_ovf[1]);
        chk("busy", busy, busy_e);
        @(posedge clk);
        edges++;
        if (g != 2'b00) begin
            id = g[1];
            tt = id ? req1_t : req0_t;
`ifdef FADD_ARB_SUB_EN
            if (id ? req1_sub : req0_sub) tt = tt ^ 32'h8000_0000;
`endif
            res = ovr ? ovr_res : ref_add(id ? req1_s : req0_s, tt);
            q.push_back('{edges + 1, id, res[31:0], res[32]});
            ptr_m = ~id;
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic [1:0] g;
        for (int i = 0; i < n; i++) step(1'b0, 33'd0, g);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q.delete();
        ptr_m       = 1'b0;
        last_d[0]   = '0;
        last_d[1]   = '0;
        last_ovf[0] = 1'b0;
        last_ovf[1] = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        vec_t        tbl[12];
        logic [1:0]  g;
        logic [1:0]  lg;
        logic [7:0]  seq;
        bit          p;

        tbl[0]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
        tbl[1]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1};
        tbl[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0};
        tbl[4]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0};
        tbl[5]  = '{32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b0};
        tbl[6]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0};
        tbl[7]  = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, 1'b0};
        tbl[8]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0};
        tbl[9]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0};
        tbl[10] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
        tbl[11] = '{32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, 1'b0};

        rst = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_s = '0; req0_t = '0; req1_s = '0; req1_t = '0;
        req0_sub = 1'b0; req1_sub = 1'b0;
        apply_reset();

        // req0 alone: 1 + 2 = 3, first edge after release.
        req0_valid = 1'b1; req0_s = 32'h3F80_0000; req0_t = 32'h4000_0000;
        step(1'b1, {1'b0, 32'h4040_0000}, g);
        req0_valid = 1'b0;
        idle(3);

        // Contention from reset: grants must alternate 0,1,0,1.
        apply_reset();
        seq = '0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_s = rnd_op(); req0_t = rnd_op(); req1_s = rnd_op(); req1_t = rnd_op();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 33'd0, g);
            seq = {seq[5:0], g};
            if (g[0]) begin req0_s = rnd_op(); req0_t = rnd_op(); end
            if (g[1]) begin req1_s = rnd_op(); req1_t = rnd_op(); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("grant_order", seq, 8'b01_10_01_10);
        idle(3);

        // Hold with both valid: nothing granted; release goes to the pointer's requester.
        hold = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        idle(3);
        p = ptr_m;
        hold = 1'b0;
        step(1'b0, 33'd0, g);
        chk("hold_release", g, p ? 2'b10 : 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(3);

        // Reset the cycle after a transfer: the in-flight op must vanish.
        req0_valid = 1'b1; req0_s = rnd_op(); req0_t = rnd_op();
        step(1'b0, 33'd0, g);
        req0_valid = 1'b0;
        apply_reset();
        idle(3);
        req1_valid = 1'b1; req1_s = 32'h3F80_0000; req1_t = 32'h4000_0000;
        step(1'b1, {1'b0, 32'h4040_0000}, g);
        chk("post_reset_grant", g, 2'b10);
        req1_valid = 1'b0;
        idle(3);

        // Directed operand table, alternating requesters back-to-back.
        for (int i = 0; i < 12; i++) begin
            req0_valid = (i % 2 == 0);
            req1_valid = (i % 2 == 1);
            if (i % 2 == 0) begin req0_s = tbl[i].s; req0_t = tbl[i].t; end
            else            begin req1_s = tbl[i].s; req1_t = tbl[i].t; end
            step(1'b1, {tbl[i].ovf, tbl[i].d}, g);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(3);

`ifdef FADD_ARB_SUB_EN
        req0_valid = 1'b1; req0_s = 32'h4040_0000; req0_t = 32'h3F80_0000; req0_sub = 1'b1;
        step(1'b1, {1'b0, 32'h4000_0000}, g);
        req0_valid = 1'b0; req0_sub = 1'b0;
        idle(3);
`endif

        // Randomised traffic against the real-arithmetic model.
        lg = 2'b00;
        for (int i = 0; i < 400; i++) begin
            hold = ($urandom_range(4, 0) == 0);
            if (!(req0_valid && !lg[0])) begin
                req0_valid = ($urandom_range(2, 0) != 0);
                req0_s = rnd_op(); req0_t = rnd_op(); req0_sub = 1'($urandom);
            end else if ($urandom_range(7, 0) == 0) begin
                req0_valid = 1'b0;
            end
            if (!(req1_valid && !lg[1])) begin
                req1_valid = ($urandom_range(2, 0) != 0);
                req1_s = rnd_op(); req1_t = rnd_op(); req1_sub = 1'($urandom);
            end else if ($urandom_range(7, 0) == 0) begin
                req1_valid = 1'b0;
            end
            step(1'b0, 33'd0, lg);
        end
        hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        idle(4);
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fadd_arb.md
FADD_ARB -- requirements
Module: fadd_arb

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 hold  input  1  when high, no new request is granted; in-flight operations still complete.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle; a transfer occurs at a rising edge where valid and ready are both high.
REQ-006 req0_s, req0_t / req1_s, req1_t  input  32  IEEE-754 single-precision operands.
REQ-007 req0_sub / req1_sub  input  1  subtract request; present only with FADD_ARB_SUB_EN.
REQ-008 resp0_valid / resp1_valid  output  1  result for requester n, one-cycle pulse.
REQ-009 resp0_d / resp1_d  output  32  result word.
REQ-010 resp0_ovf / resp1_ovf  output  1  overflow flag from the shared adder.
REQ-011 busy  output  1  high while any accepted operation has not yet produced its response.

Function
REQ-012 The block instantiates exactly one combinational fadd datapath (s, t -> d, overflow) and shares it between the two requesters.
REQ-013 Arbitration: at most one ready per cycle. Ready is combinational from valid, hold and the priority pointer.
REQ-014 If hold=1, both readys are 0.
REQ-015 If exactly one valid is high, that requester gets ready.
REQ-016 If both valids are high, the requester named by the 1-bit priority pointer gets ready.
REQ-017 The pointer changes only on a transfer, and it then points to the requester that was not served.
REQ-018 Stage 1 (S1): on transfer, register s, t, the requester id and the valid bit. S1 valid clears when there is no transfer.
REQ-019 Stage 2 (S2): S1 feeds the fadd. The edge after S1 is loaded, register d, the overflow flag and the id into output registers.
REQ-020 Latency: transfer at edge k gives respN_valid high for exactly the cycle between edges k+1 and k+2.
REQ-021 Throughput: one operation per cycle, back-to-back.
REQ-022 Responses cannot be back-pressured. Order is preserved, and each response is routed only to the id that issued it.
REQ-023 respN_d and respN_ovf hold their last value while respN_valid=0. The respN_valid of the non-target requester stays 0.
REQ-024 busy = S1 valid OR respN_valid (either requester).
REQ-025 Operand values pass to the fadd unmodified. NaN, inf and denormal handling are entirely the datapath's.
REQ-026 Valid deasserted while ready was high (no transfer edge reached) has no effect. Requesters hold operands stable while valid is high and not yet accepted.

Reset
REQ-027 While rst=1: S1 valid=0, both respN_valid=0, respN_d=0, respN_ovf=0, pointer=0 (requester 0 first), busy=0.
REQ-028 Readys are 0 while rst=1.
REQ-029 Reset asserted mid-operation discards all in-flight operations. No response is ever produced for them after reset.
REQ-030 The first grant after reset release can occur at the first rising edge with rst low.

Configuration
REQ-031 Macro FADD_ARB_SUB_EN.
- Defined: reqN_sub exists and is registered into S1 with the operands. When it is 1, bit 31 of t is inverted before entering the fadd, so d = s - t.
- Undefined: reqN_sub ports are absent and t is passed unchanged (add only).

Verification
REQ-032 req0 only: s=0x3F800000, t=0x40000000. Transfer at edge 1 -> resp0_valid in the cycle after edge 2, resp0_d=0x40400000, resp0_ovf=0, resp1_valid=0.
REQ-033 Both valid for 4 cycles after reset -> grants in order 0,1,0,1. Responses alternate with matching ids, one per cycle, and busy stays high until the last response.
REQ-034 Overflow: s=t=0x7F7FFFFF on req1 -> resp1_d=0x7F800000, resp1_ovf=1.
REQ-035 hold=1 with both valid for 3 cycles -> no ready and no resp. On hold release, the grant goes to the pointer's requester.
REQ-036 Reset asserted the cycle after a transfer -> no resp pulse at any later time. After release, a new req1 transfer completes normally.
REQ-037 With FADD_ARB_SUB_EN: req0 s=0x40400000, t=0x3F800000, sub=1 -> resp0_d=0x40000000. Without the macro, the same operands (no sub port) give 0x40800000.
